// File: rtl/i2c_master_if.sv
// Command/response handshake and open-drain line signals of the I2C byte controller.
interface i2c_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       rd_ack;
    logic       rsp_valid;
    logic [7:0] rdata;
    logic       nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  cmd_valid, cmd, wdata, rd_ack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rdata, nack, busy, scl_oe, sda_oe, scl_o, sda_o
    );

    modport slave (
        output cmd_valid, cmd, wdata, rd_ack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rdata, nack, busy, scl_oe, sda_oe, scl_o, sda_o
    );
endinterface

// File: rtl/i2c_master.sv
// Byte-level I2C controller executing START / WRITE / READ / STOP commands on open-drain lines.
// Define I2C_MASTER_STRETCH_EN to let a responder stretch SCL during the high quarter (q1).
module i2c_master #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0]  CMD_START = 2'b00;
    localparam logic [1:0]  CMD_WRITE = 2'b01;
    localparam logic [1:0]  CMD_READ  = 2'b10;
    localparam logic [1:0]  CMD_STOP  = 2'b11;
    localparam logic [15:0] CNT_LAST  = 16'(CLKDIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        rd_ack_q, rd_ack_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;

    logic accept_s;
    logic running_s;
    logic hold_s;
    logic tick_s;
    logic last_qtr_s;

    assign accept_s  = bus.cmd_valid & cmd_ready_q;
    assign running_s = (state_q == S_START) | (state_q == S_BIT) |
                       (state_q == S_ACK)   | (state_q == S_STOP);
`ifdef I2C_MASTER_STRETCH_EN
    // While the responder keeps SCL low in q1 the quarter counter stays at zero.
    assign hold_s = running_s & (qtr_q == 2'd1) & ~bus.scl_i;
`else
    assign hold_s = 1'b0;
`endif
    assign tick_s     = running_s & ~hold_s & (cnt_q == CNT_LAST);
    assign last_qtr_s = tick_s & (qtr_q == 2'd3);

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.nack      = nack_q;
    assign bus.busy      = busy_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.scl_o     = 1'b0;
    assign bus.sda_o     = 1'b0;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            qtr_q       <= 2'd0;
            bit_q       <= 3'd0;
            sh_q        <= 8'h00;
            cmd_q       <= 2'b00;
            rd_ack_q    <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            cmd_q       <= cmd_d;
            rd_ack_q    <= rd_ack_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    // Next-state logic; bus commands without bus ownership finish immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    case (bus.cmd)
                        CMD_START: state_d = S_START;
                        CMD_WRITE: state_d = busy_q ? S_BIT : S_DONE;
                        CMD_READ:  state_d = busy_q ? S_BIT : S_DONE;
                        CMD_STOP:  state_d = busy_q ? S_STOP : S_DONE;
                        default:   state_d = S_DONE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START, S_ACK, S_STOP: begin
                if (last_qtr_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            S_BIT: begin
                if (last_qtr_s && (bit_q == 3'd7)) begin
                    state_d = S_ACK;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Quarter/bit sequencing, shift register and line sampling.
    always_comb begin
        cnt_d    = cnt_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        cmd_d    = cmd_q;
        rd_ack_d = rd_ack_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        if (accept_s) begin
            cnt_d    = 16'd0;
            qtr_d    = 2'd0;
            bit_d    = 3'd0;
            cmd_d    = bus.cmd;
            rd_ack_d = bus.rd_ack;
            sh_d     = (bus.cmd == CMD_WRITE) ? bus.wdata : 8'h00;
        end else if (running_s) begin
            cnt_d = (tick_s || hold_s) ? 16'd0 : (cnt_q + 16'd1);
            if (tick_s) begin
                qtr_d = qtr_q + 2'd1;
                if ((qtr_q == 2'd2) && (state_q == S_BIT)) begin
                    sh_d = {sh_q[6:0], bus.sda_i};
                end else if ((qtr_q == 2'd2) && (state_q == S_ACK)) begin
                    ack_d = bus.sda_i;
                end else begin
                    sh_d = sh_q;
                end
                bit_d = ((qtr_q == 2'd3) && (state_q == S_BIT)) ? (bit_q + 3'd1) : bit_q;
            end else begin
                qtr_d = qtr_q;
            end
            if (last_qtr_s && (state_q == S_START)) begin
                busy_d = 1'b1;
            end else if (last_qtr_s && (state_q == S_STOP)) begin
                busy_d = 1'b0;
            end else begin
                busy_d = busy_q;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Output next values: handshake/response plus SCL/SDA levels at each quarter entry.
    always_comb begin
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        nack_d      = nack_q;
        rdata_d     = rdata_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        if (state_d == S_DONE) begin
            cmd_ready_d = 1'b1;
            rsp_valid_d = 1'b1;
            if (!running_s) begin
                nack_d = 1'b1;
            end else if ((state_q == S_ACK) && (cmd_q == CMD_WRITE)) begin
                nack_d = ack_q;
            end else begin
                nack_d = 1'b0;
            end
            if ((state_q == S_ACK) && (cmd_q == CMD_READ)) begin
                rdata_d = sh_q;
            end else begin
                rdata_d = rdata_q;
            end
        end else if (accept_s) begin
            cmd_ready_d = 1'b0;
        end else begin
            cmd_ready_d = cmd_ready_q;
        end

        if (accept_s || tick_s) begin
            case (state_d)
                S_START: begin
                    case (qtr_d)
                        2'd0:    sda_oe_d = 1'b0;
                        2'd1:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                        2'd2:    begin scl_oe_d = 1'b0; sda_oe_d = 1'b1; end
                        default: begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                    endcase
                end
                S_BIT, S_ACK: begin
                    case (qtr_d)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            if (state_d == S_ACK) begin
                                sda_oe_d = (cmd_d == CMD_READ) ? rd_ack_d : 1'b0;
                            end else begin
                                sda_oe_d = (cmd_d == CMD_WRITE) ? ~sh_d[7] : 1'b0;
                            end
                        end
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    scl_oe_d = 1'b0;
                        default: scl_oe_d = 1'b1;
                    endcase
                end
                S_STOP: begin
                    case (qtr_d)
                        2'd0:    begin scl_oe_d = 1'b1; sda_oe_d = 1'b1; end
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    scl_oe_d = 1'b0;
                        default: begin scl_oe_d = 1'b0; sda_oe_d = 1'b0; end
                    endcase
                end
                default: begin
                    scl_oe_d = scl_oe_q;
                    sda_oe_d = sda_oe_q;
                end
            endcase
        end else begin
            scl_oe_d = scl_oe_q;
            sda_oe_d = sda_oe_q;
        end
    end
endmodule
